// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, mem_op bit positions and bus layouts for the
// memory-access stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 154;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_RF_WD = 104;
    localparam int STALL_BUS_WD = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;

    // Bit positions inside the 8-bit mem_op field
    localparam int OP_SW  = 7;
    localparam int OP_LW  = 6;
    localparam int OP_LB  = 5;
    localparam int OP_LBU = 4;
    localparam int OP_LH  = 3;
    localparam int OP_LHU = 2;
    localparam int OP_SB  = 1;
    localparam int OP_SH  = 0;

    typedef struct packed {
        logic [31:0] lo;
        logic        lo_we;
        logic [31:0] hi;
        logic        hi_we;
        logic [7:0]  mem_op;
        logic [3:0]  data_ram_sel;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] lo;
        logic        lo_we;
        logic [31:0] hi;
        logic        hi_we;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic [31:0] lo;
        logic        lo_we;
        logic [31:0] hi;
        logic        hi_we;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_rf_t;

endpackage

// File: rtl/mem_stage_if.sv
// Buses around the memory-access stage: stall vector, EX->MEM bus, SRAM read
// data in; MEM->WB and forwarding buses out.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [STALL_BUS_WD-1:0] stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;

    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_rf_bus
    );

    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_rf_bus
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load lane selection and sign/zero extension of the SRAM read word.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  addr,
    input  logic [7:0]  mem_op,
    output logic [31:0] ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        unused_ops;

    // Stores carry no load data; their op bits are deliberately ignored
    assign unused_ops = ^{mem_op[OP_SW], mem_op[OP_SB], mem_op[OP_SH]};

    always_comb begin
        byte_lane = rd[7:0];
        half_lane = rd[15:0];
        ext       = '0;

        case (addr)
            2'd0: byte_lane = rd[7:0];
            2'd1: byte_lane = rd[15:8];
            2'd2: byte_lane = rd[23:16];
            2'd3: byte_lane = rd[31:24];
            default: byte_lane = rd[7:0];
        endcase

        // Misaligned halfword/word accesses take the lane without trapping
        half_lane = addr[1] ? rd[31:16] : rd[15:0];

        if (mem_op[OP_LW]) begin
            ext = rd;
        end else if (mem_op[OP_LB]) begin
            ext = {{24{byte_lane[7]}}, byte_lane};
        end else if (mem_op[OP_LBU]) begin
            ext = {24'd0, byte_lane};
        end else if (mem_op[OP_LH]) begin
            ext = {{16{half_lane[15]}}, half_lane};
        end else if (mem_op[OP_LHU]) begin
            ext = {16'd0, half_lane};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register under stall control, load
// data buffering/extension, MEM->WB and forwarding bus packing.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave bus
);

    ex_to_mem_t  bus_r;
    logic        fresh;
    logic [31:0] rdata_buf;
    logic [31:0] rd;
    logic [31:0] load_val;
    logic [31:0] rf_wdata;
    logic        take_new;
    logic        insert_bubble;
    logic        unused_fields;
    mem_to_wb_t  wb;
    mem_to_rf_t  rf;

    assign insert_bubble = (bus.stall[STALL_EX_MEM] == STOP) &&
                           (bus.stall[STALL_MEM_WB] == NO_STOP);
    assign take_new      = (bus.stall[STALL_EX_MEM] == NO_STOP);

    assign unused_fields = ^{bus_r.data_ram_sel, bus_r.data_ram_en, bus_r.data_ram_wen,
                             bus.stall[5], bus.stall[2:0]};

    // EX -> MEM register; fresh marks the first cycle an entry sits in MEM,
    // the only cycle the SRAM output belongs to it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_r     <= '0;
            fresh     <= 1'b0;
            rdata_buf <= '0;
        end else begin
            if (fresh) begin
                rdata_buf <= bus.data_sram_rdata;
            end
            if (insert_bubble) begin
                bus_r <= '0;
                fresh <= 1'b0;
            end else if (take_new) begin
                bus_r <= ex_to_mem_t'(bus.ex_to_mem_bus);
                fresh <= 1'b1;
            end else begin
                fresh <= 1'b0;
            end
        end
    end

    // MEM combinational: live SRAM word on the first cycle, buffered afterwards
    assign rd = fresh ? bus.data_sram_rdata : rdata_buf;

    mem_load_ext u_load_ext (
        .rd     (rd),
        .addr   (bus_r.ex_result[1:0]),
        .mem_op (bus_r.mem_op),
        .ext    (load_val)
    );

    assign rf_wdata = bus_r.sel_rf_res ? load_val : bus_r.ex_result;

    always_comb begin
        wb          = '0;
        wb.lo       = bus_r.lo;
        wb.lo_we    = bus_r.lo_we;
        wb.hi       = bus_r.hi;
        wb.hi_we    = bus_r.hi_we;
        wb.pc       = bus_r.pc;
        wb.rf_we    = bus_r.rf_we;
        wb.rf_waddr = bus_r.rf_waddr;
        wb.rf_wdata = rf_wdata;

        rf          = '0;
        rf.lo       = bus_r.lo;
        rf.lo_we    = bus_r.lo_we;
        rf.hi       = bus_r.hi;
        rf.hi_we    = bus_r.hi_we;
        rf.rf_we    = bus_r.rf_we;
        rf.rf_waddr = bus_r.rf_waddr;
        rf.rf_wdata = rf_wdata;
    end

    assign bus.mem_to_wb_bus = wb;
    assign bus.mem_to_rf_bus = rf;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a behavioural model of
// instruction occupancy and first-cycle load data capture.
module tb_mem_stage;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    mem_stage_if bus_if ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: which instruction occupies MEM, whether this is its first cycle,
    // and the SRAM word it saw on that first cycle.
    logic [153:0] m_bus   = '0;
    bit           m_first = 1'b0;
    logic [31:0]  m_word  = '0;

    logic [135:0] last_wb;
    logic [103:0] last_rf;

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_HOLD = 6'b011000;
    localparam logic [5:0] ST_BUBL = 6'b001000;
    localparam logic [5:0] ST_WB   = 6'b010000;

    localparam logic [7:0] M_SW  = 8'b1000_0000;
    localparam logic [7:0] M_LW  = 8'b0100_0000;
    localparam logic [7:0] M_LB  = 8'b0010_0000;
    localparam logic [7:0] M_LBU = 8'b0001_0000;
    localparam logic [7:0] M_LH  = 8'b0000_1000;
    localparam logic [7:0] M_LHU = 8'b0000_0100;

    task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [7:0] op, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a));
        h = 16'(w >> (16 * a[1]));
        if (op[6]) return w;
        if (op[5]) return 32'($signed(b));
        if (op[4]) return 32'(b);
        if (op[3]) return 32'($signed(h));
        if (op[2]) return 32'(h);
        return 32'd0;
    endfunction

    function automatic logic [153:0] rand_bus();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[153:0];
    endfunction

    function automatic logic [153:0] mk_bus(input logic [7:0] op, input logic sel, input logic we,
                                            input logic [31:0] res, input logic hiwe,
                                            input logic [31:0] hi);
        logic [153:0] b;
        b          = rand_bus();
        b[87:80]   = op;
        b[38]      = sel;
        b[37]      = we;
        b[31:0]    = res;
        b[88]      = hiwe;
        b[120:89]  = hi;
        return b;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic cycle(input logic rstn, input logic [5:0] st, input logic [153:0] eb,
                         input logic [31:0] rd, input bit chk, input logic [31:0] exp_w,
                         input string tag);
        logic [31:0]  word;
        logic [31:0]  wdata;
        logic [135:0] exp_wb;
        logic [103:0] exp_rf;
        resetn                 = rstn;
        bus_if.stall           = st;
        bus_if.ex_to_mem_bus   = eb;
        bus_if.data_sram_rdata = rd;
        #3;
        word   = m_first ? rd : m_word;
        wdata  = m_bus[38] ? load_value(m_bus[87:80], m_bus[1:0], word) : m_bus[31:0];
        exp_wb = {m_bus[153:122], m_bus[121], m_bus[120:89], m_bus[88], m_bus[75:44],
                  m_bus[37], m_bus[36:32], wdata};
        exp_rf = {m_bus[153:122], m_bus[121], m_bus[120:89], m_bus[88],
                  m_bus[37], m_bus[36:32], wdata};
        last_wb = bus_if.mem_to_wb_bus;
        last_rf = bus_if.mem_to_rf_bus;
        check_val({tag, "_wb"}, last_wb, exp_wb);
        check_val({tag, "_rf"}, 136'(last_rf), 136'(exp_rf));
        if (chk) check_val(tag, 136'(last_wb[31:0]), 136'(exp_w));
        @(posedge clk);
        if (m_first) m_word = rd;
        if (!rstn) begin
            m_bus   = '0;
            m_first = 1'b0;
            m_word  = '0;
        end else if (st[3] && !st[4]) begin
            m_bus   = '0;
            m_first = 1'b0;
        end else if (!st[3]) begin
            m_bus   = eb;
            m_first = 1'b1;
        end else begin
            m_first = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [5:0]   st;
        logic [7:0]   op;
        logic [153:0] eb;
        int           r;

        resetn                 = 1'b0;
        bus_if.stall           = ST_NONE;
        bus_if.ex_to_mem_bus   = mk_bus(M_LW, 1'b1, 1'b1, 32'h0000_1000, 1'b1, 32'h1111_2222);
        bus_if.data_sram_rdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with a live bus, then release and first instruction
        cycle(1'b0, ST_NONE, mk_bus(M_LW, 1'b1, 1'b1, 32'h10, 1'b1, 32'h3), 32'h1, 1'b1, 32'd0, "rst_hold");
        check_val("rst_zero_wb", last_wb, 136'd0);
        check_val("rst_zero_rf", 136'(last_rf), 136'd0);
        cycle(1'b1, ST_NONE, mk_bus(8'd0, 1'b0, 1'b1, 32'h1234, 1'b0, 32'd0), 32'h2, 1'b1, 32'd0, "rst_rel0");
        cycle(1'b1, ST_NONE, mk_bus(M_LB, 1'b1, 1'b1, 32'h1003, 1'b0, 32'd0), 32'h3, 1'b1, 32'h1234, "rst_rel1");

        // Byte / halfword / word extension cases
        cycle(1'b1, ST_NONE, mk_bus(M_LBU, 1'b1, 1'b1, 32'h1003, 1'b0, 32'd0), 32'h80FF_1234, 1'b1, 32'hFFFF_FF80, "lb");
        cycle(1'b1, ST_NONE, mk_bus(M_LH, 1'b1, 1'b1, 32'h2002, 1'b0, 32'd0), 32'h80FF_1234, 1'b1, 32'h0000_0080, "lbu");
        cycle(1'b1, ST_NONE, mk_bus(M_LHU, 1'b1, 1'b1, 32'h2002, 1'b0, 32'd0), 32'h8001_7FFF, 1'b1, 32'hFFFF_8001, "lh");
        cycle(1'b1, ST_NONE, mk_bus(M_LW, 1'b1, 1'b1, 32'h2002, 1'b0, 32'd0), 32'h8001_7FFF, 1'b1, 32'h0000_8001, "lhu");
        cycle(1'b1, ST_NONE, mk_bus(M_LW, 1'b1, 1'b1, 32'h3000, 1'b0, 32'd0), 32'h8001_7FFF, 1'b1, 32'h8001_7FFF, "lw");

        // Held load: first cycle live data, later cycles buffered; then bubble
        cycle(1'b1, ST_HOLD, rand_bus(), 32'h1234_5678, 1'b1, 32'h1234_5678, "hold1");
        cycle(1'b1, ST_HOLD, rand_bus(), 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "hold2");
        cycle(1'b1, ST_BUBL, rand_bus(), 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "hold3");
        cycle(1'b1, ST_NONE, mk_bus(8'd0, 1'b0, 1'b1, 32'h55, 1'b0, 32'd0), 32'h7777_7777, 1'b1, 32'd0, "bubble");
        check_val("bubble_ctl", 136'({last_wb[103], last_wb[70], last_wb[37], last_wb[69:38]}), 136'd0);

        // HI passthrough on both buses, store keeps rf_we=0
        cycle(1'b1, ST_NONE, mk_bus(8'd0, 1'b0, 1'b0, 32'h99, 1'b1, 32'hCAFE_0001), 32'h0, 1'b1, 32'h55, "alu");
        cycle(1'b1, ST_NONE, mk_bus(M_SW, 1'b0, 1'b0, 32'h4000, 1'b0, 32'd0), 32'h0, 1'b0, 32'd0, "mthi");
        check_val("mthi_wb", 136'({last_wb[102:71], last_wb[70]}), 136'({32'hCAFE_0001, 1'b1}));
        check_val("mthi_rf", 136'({last_rf[70:39], last_rf[38]}), 136'({32'hCAFE_0001, 1'b1}));
        cycle(1'b1, ST_NONE, mk_bus(M_LW, 1'b1, 1'b1, 32'h5000, 1'b1, 32'd7), 32'h0, 1'b0, 32'd0, "sw");
        check_val("sw_rf_we_wb", 136'(last_wb[37]), 136'd0);
        check_val("sw_rf_we_rf", 136'(last_rf[37]), 136'd0);

        // Reset in the middle of a held load
        cycle(1'b1, ST_HOLD, rand_bus(), 32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F, "pre_rst");
        cycle(1'b0, ST_HOLD, rand_bus(), 32'h1357_9BDF, 1'b1, 32'hA5A5_0F0F, "rst_in_hold");
        cycle(1'b1, ST_HOLD, rand_bus(), 32'h2468_ACE0, 1'b0, 32'd0, "rst_mid");
        check_val("rst_mid_wb", last_wb, 136'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       st = ST_NONE;
            else if (r < 8)  st = ST_HOLD;
            else if (r == 8) st = ST_BUBL;
            else             st = ST_WB;
            case ($urandom_range(0, 7))
                0: op = M_LW;
                1: op = M_LB;
                2: op = M_LBU;
                3: op = M_LH;
                4: op = M_LHU;
                5: op = M_SW;
                6: op = 8'd0;
                default: op = 8'(1 << $urandom_range(0, 7));
            endcase
            eb = mk_bus(op, ($urandom_range(0, 3) != 0) ? |op[6:2] : 1'($urandom),
                        1'($urandom), $urandom, 1'($urandom), $urandom);
            cycle(($urandom_range(0, 60) != 0), st, eb, $urandom, 1'b0, 32'd0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage, directly downstream of the execute stage. Registers the EX→MEM bus under stall control and aligns and extends load data from the synchronous data SRAM. Drives the MEM→WB bus and a forwarding bus back to decode for GPR and HI/LO results. Load data is buffered so a stalled load keeps its value after the SRAM output moves on.

## Interface
Parameters: none; widths come from the shared defines.

- `clk` in 1: core clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `stall` in `StallBus` (6): global stall vector.
  - bit 3 freezes the EX→MEM register.
  - bit 4 freezes MEM→WB.
- `ex_to_mem_bus` in `EX_TO_MEM_WD` (154): fields, MSB first:
  - lo 153:122, lo_we 121, hi 120:89, hi_we 88
  - mem_op 87:80 = {sw,lw,lb,lbu,lh,lhu,sb,sh}
  - data_ram_sel 79:76, pc 75:44, data_ram_en 43, data_ram_wen 42:39
  - sel_rf_res 38, rf_we 37, rf_waddr 36:32, ex_result 31:0
- `data_sram_rdata` in 32: SRAM read data, valid in the cycle after EX issues the request.
- `mem_to_wb_bus` out `MEM_TO_WB_WD` (136): {lo, lo_we, hi, hi_we, pc, rf_we, rf_waddr, rf_wdata}.
- `mem_to_rf_bus` out `MEM_TO_RF_WD` (104): {lo, lo_we, hi, hi_we, rf_we, rf_waddr, rf_wdata}, for forwarding.

## Operation
Pipeline register `bus_r`, updated at each rising edge in this priority order:
- `resetn`=0 → 0.
- else `stall[3]`=Stop and `stall[4]`=NoStop → 0 (bubble).
- else `stall[3]`=NoStop → `ex_to_mem_bus`.
- else hold.

Load-data buffer: 1-bit `fresh`, 32-bit `rdata_buf`.
- `fresh` is set for exactly the cycle after `bus_r` loads a new bus; it is cleared otherwise and on reset.
- When `fresh`=1, `rdata_buf` ← `data_sram_rdata`.
- Effective read word: `rd = fresh ? data_sram_rdata : rdata_buf`.

Load extension (addr = ex_result[1:0]):
- lw: rd.
- lb / lbu: rd byte at addr (addr 0 → [7:0], addr 3 → [31:24]), then sign- or zero-extend to 32.
- lh / lhu: addr[1]=0 → rd[15:0], else rd[31:16], then sign- or zero-extend.
- No load bit set: 0.
- Misaligned halfword/word: no exception; uses the lanes above.

Output data and fields:
- `rf_wdata` = sel_rf_res ? extended load : ex_result.
- pc, rf_we, rf_waddr, hi/lo fields and their write enables pass through from `bus_r` unchanged.
- Stores need no MEM action; a store's rf_we=0 is passed through.

## Timing
- All outputs are combinational from `bus_r`, `fresh`, `rdata_buf` and `data_sram_rdata`; zero added latency.
- One instruction occupies MEM for at least one cycle.
- Reset: `bus_r`=0, `fresh`=0, `rdata_buf`=0, so both output buses are all-zero (rf_we=hi_we=lo_we=0).
- Held load (stall[3]=stall[4]=Stop) across N cycles:
  - cycle 1 uses the live SRAM data;
  - cycles 2..N use `rdata_buf`;
  - `rf_wdata` stays constant even if `data_sram_rdata` changes.
- Bubble insertion clears `fresh` next cycle; a bubble never loads the buffer with meaningful data.
- Back-to-back loads: each new entry re-sets `fresh`, so there is no stale carry-over.
- Reset asserted mid-hold overrides everything; the next cycle outputs are zero.

## Structure
- Shared defines header holds:
  - `EX_TO_MEM_WD`=154, `MEM_TO_WB_WD`=136, `MEM_TO_RF_WD`=104, `StallBus`=6
  - `Stop`=1'b1, `NoStop`=1'b0
  - mem_op bit positions as named constants
- Sub-module `mem_load_ext` (combinational): inputs rd, addr[1:0], mem_op; output is the 32-bit extended value.
- Top level holds `bus_r`, `fresh`, `rdata_buf` and the bus packing.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with a non-zero input bus → both output buses are 0; after release with no stall, the output equals the input fields one cycle later.
- lb with ex_result=0x1003, rdata=0x80FF_1234, sel_rf_res=1 → rf_wdata=0xFFFF_FF80. The same case with lbu → 0x0000_0080.
- lh at addr 0x2002 with rdata=0x8001_7FFF → 0xFFFF_8001; lhu → 0x0000_8001; lw → 0x8001_7FFF.
- Load held 3 cycles (stall[3]=stall[4]=1), rdata=0x1234_5678 in cycle 1 then 0xDEAD_BEEF → rf_wdata=0x1234_5678 in all 3 cycles.
- stall[3]=1, stall[4]=0 → next cycle rf_we=hi_we=lo_we=0 and pc=0 (bubble); a following unstalled ALU op (sel_rf_res=0, ex_result=0x55) → rf_wdata=0x55.
- mthi passthrough: hi_we=1, hi=0xCAFE_0001 → appears on both `mem_to_wb_bus` and `mem_to_rf_bus` in the same cycle; rf_we=0 on a store (sw) is propagated.
